// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder that loads encoded instructions sequentially into instruction memory.
// One bundle per three cycles: latch (IDLE), validate/encode (ENC), single-cycle write (WR).
module instr_encoder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_reg;
  logic [2:0]            fmt_reg;
  logic [6:0]            opcode_reg;
  logic [2:0]            funct3_reg;
  logic                  funct7_5_reg;
  logic [4:0]            rd_reg;
  logic [4:0]            rs1_reg;
  logic [4:0]            rs2_reg;
  logic [31:0]           imm_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [31:0]           enc_word;
  logic                  enc_ok;

  assign full     = (count_reg == CAPACITY);
  assign count    = count_reg;
  assign mem_addr = ptr_reg;
  // rst_n is folded in so the source sees no ready while the block is held in reset.
  assign in_ready = rst_n && (state_reg == IDLE) && !full && !clear;

  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    case (fmt_reg)
      3'b000: begin
        enc_word = {imm_reg[11:0], rs1_reg, funct3_reg, rd_reg, opcode_reg};
        enc_ok   = (imm_reg[31:11] == {21{imm_reg[11]}});
      end
      3'b001: begin
        enc_word = {1'b0, funct7_5_reg, 5'b0, imm_reg[4:0], rs1_reg, funct3_reg, rd_reg, opcode_reg};
        enc_ok   = (imm_reg[31:5] == 27'h0);
      end
      3'b010: begin
        enc_word = {imm_reg[11:5], rs2_reg, rs1_reg, funct3_reg, imm_reg[4:0], opcode_reg};
        enc_ok   = (imm_reg[31:11] == {21{imm_reg[11]}});
      end
      3'b011: begin
        enc_word = {imm_reg[12], imm_reg[10:5], rs2_reg, rs1_reg, funct3_reg,
                    imm_reg[4:1], imm_reg[11], opcode_reg};
        enc_ok   = !imm_reg[0] && (imm_reg[31:12] == {20{imm_reg[12]}});
      end
      3'b100: begin
        enc_word = {imm_reg[31:12], rd_reg, opcode_reg};
        enc_ok   = (imm_reg[11:0] == 12'h0);
      end
      3'b101: begin
        enc_word = {imm_reg[20], imm_reg[10:1], imm_reg[11], imm_reg[19:12], rd_reg, opcode_reg};
        enc_ok   = !imm_reg[0] && (imm_reg[31:21] == {11{imm_reg[20]}});
      end
      3'b110: begin
        enc_word = {1'b0, funct7_5_reg, 5'b0, rs2_reg, rs1_reg, funct3_reg, rd_reg, opcode_reg};
      end
      3'b111: begin
        enc_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fmt_reg      <= 3'b0;
      opcode_reg   <= 7'b0;
      funct3_reg   <= 3'b0;
      funct7_5_reg <= 1'b0;
      rd_reg       <= 5'b0;
      rs1_reg      <= 5'b0;
      rs2_reg      <= 5'b0;
      imm_reg      <= 32'h0;
      ptr_reg      <= '0;
      count_reg    <= '0;
      err          <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= 32'h0;
    end else if (clear) begin
      // Abort whatever is in flight; the latched word is simply never written.
      state_reg <= IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            fmt_reg      <= fmt;
            opcode_reg   <= opcode;
            funct3_reg   <= funct3;
            funct7_5_reg <= funct7_5;
            rd_reg       <= rd;
            rs1_reg      <= rs1;
            rs2_reg      <= rs2;
            imm_reg      <= imm;
            state_reg    <= ENC;
          end
        end
        ENC: begin
          if (enc_ok) begin
            mem_wdata <= enc_word;
            mem_we    <= 1'b1;
            state_reg <= WR;
          end else begin
            err       <= 1'b1;
            state_reg <= IDLE;
          end
        end
        WR: begin
          mem_we    <= 1'b0;
          ptr_reg   <= ptr_reg + 1'b1;
          count_reg <= count_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program loads plus randomized bundles
// compared against an arithmetic reference encoder and a loader-state model.
module tb_instr_encoder;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = 3'b0;
  logic [6:0]    opcode = 7'b0;
  logic [2:0]    funct3 = 3'b0;
  logic          funct7_5 = 1'b0;
  logic [4:0]    rd = 5'b0;
  logic [4:0]    rs1 = 5'b0;
  logic [4:0]    rs2 = 5'b0;
  logic [31:0]   imm = 32'h0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_err    = 1'b0;
  logic [31:0] last_wdata = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Legality from numeric ranges of the immediate rather than bit patterns.
  function automatic bit ref_legal(input logic [2:0] f, input logic [31:0] v);
    int s;
    s = signed'(v);
    case (f)
      3'd0, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd1:       return v < 32;
      3'd3:       return (s % 2 == 0) && (s >= -4096) && (s <= 4095);
      3'd4:       return (v % 4096) == 0;
      3'd5:       return (s % 2 == 0) && (s >= -(1 << 20)) && (s < (1 << 20));
      3'd6:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic f75, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [31:0] v);
    logic [31:0] r1, r2, rr, ff, o;
    r1 = 32'(s1) << 15; r2 = 32'(s2) << 20; rr = 32'(d) << 7;
    ff = 32'(f3) << 12; o = 32'(op);
    case (f)
      3'd0: return ((v & 32'hFFF) << 20) + r1 + ff + rr + o;
      3'd1: return (32'(f75) << 30) + ((v & 32'h1F) << 20) + r1 + ff + rr + o;
      3'd2: return (((v >> 5) & 32'h7F) << 25) + r2 + r1 + ff + ((v & 32'h1F) << 7) + o;
      3'd3: return (((v >> 12) & 1) << 31) + (((v >> 5) & 32'h3F) << 25) + r2 + r1 + ff
                   + (((v >> 1) & 32'hF) << 8) + (((v >> 11) & 1) << 7) + o;
      3'd4: return (v & 32'hFFFFF000) + rr + o;
      3'd5: return (((v >> 20) & 1) << 31) + (((v >> 1) & 32'h3FF) << 21)
                   + (((v >> 11) & 1) << 20) + (v & 32'h000FF000) + rr + o;
      3'd6: return (32'(f75) << 30) + r2 + r1 + ff + rr + o;
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic f75, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [31:0] v);
    bit acc, ok;
    logic [31:0] w;
    acc = (m_cnt < CAP);
    ok  = ref_legal(f, v);
    w   = ref_word(f, op, f3, f75, d, s1, s2, v);
    @(negedge clk);
    fmt = f; opcode = op; funct3 = f3; funct7_5 = f75; rd = d; rs1 = s1; rs2 = s2; imm = v;
    in_valid = 1'b1;
    #1 check_val("in_ready_idle", in_ready, acc);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!acc) begin
      @(negedge clk);
      check_val("no_we_when_full", mem_we, 0);
      check_val("count_when_full", count, m_cnt);
      $display("txn fmt=%0d imm=0x%08h refused (full) count=%0d", f, v, count);
    end else begin
      @(negedge clk);
      check_val("in_ready_enc", in_ready, 0);
      check_val("we_enc", mem_we, 0);
      @(negedge clk);
      if (ok) begin
        check_val("we_wr", mem_we, 1);
        check_val("addr_wr", mem_addr, m_ptr);
        check_val("wdata_wr", mem_wdata, w);
        check_val("in_ready_wr", in_ready, 0);
        last_wdata = mem_wdata;
        @(negedge clk);
        m_ptr = (m_ptr + 1) % CAP;
        m_cnt++;
        check_val("we_after", mem_we, 0);
        check_val("count_after", count, m_cnt);
        check_val("full_after", full, m_cnt == CAP);
        check_val("err_after", err, m_err);
        check_val("in_ready_after", in_ready, m_cnt < CAP);
        $display("txn fmt=%0d imm=0x%08h written word=0x%08h count=%0d", f, v, last_wdata, count);
      end else begin
        m_err = 1'b1;
        check_val("we_reject", mem_we, 0);
        check_val("err_reject", err, 1);
        check_val("count_reject", count, m_cnt);
        check_val("in_ready_reject", in_ready, m_cnt < CAP);
        $display("txn fmt=%0d imm=0x%08h rejected err=%0d count=%0d", f, v, err, count);
      end
    end
  endtask

  // Clear is asserted together with a valid bundle, which must not be taken.
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1;
    #1 check_val("in_ready_clear", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
    check_val("clear_count", count, 0);
    check_val("clear_full", full, 0);
    check_val("clear_err", err, 0);
    check_val("clear_in_ready", in_ready, 1);
    check_val("clear_no_we", mem_we, 0);
    $display("txn clear count=%0d full=%0d err=%0d", count, full, err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_count", count, 0);
    check_val("rst_full", full, 0);
    check_val("rst_err", err, 0);
    rst_n = 1'b1;

    do_req(3'd0, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    check_val("addi_word", last_wdata, 32'h00500093);
    do_clear();
    do_req(3'd2, 7'b0100011, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    check_val("sw_word", last_wdata, 32'h0020A423);
    do_req(3'd1, 7'b0010011, 3'd5, 1'b1, 5'd5, 5'd5, 5'd0, 32'd3);
    check_val("srai_word", last_wdata, 32'h4032D293);
    do_req(3'd0, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800);
    do_req(3'd3, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7);
    do_req(3'd7, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    do_req(3'd0, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    do_req(3'd3, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    check_val("beq_word", last_wdata, 32'hFE000EE3);
    check_val("full_flag", full, 1);
    do_req(3'd0, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    do_clear();
    do_req(3'd5, 7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    check_val("jal_word", last_wdata, 32'h001000EF);
    do_clear();

    // Clear while the bundle is being encoded: nothing may be written.
    @(negedge clk);
    fmt = 3'd0; opcode = 7'b0010011; funct3 = 3'd0; rd = 5'd1; imm = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check_val("clr_enc_we", mem_we, 0);
    check_val("clr_enc_count", count, 0);
    @(negedge clk);
    check_val("clr_enc_we2", mem_we, 0);
    $display("txn clear during ENC, count=%0d", count);

    // Reset pulse while the write strobe is up.
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("pre_rst_we", mem_we, 1);
    rst_n = 1'b0;
    #1 check_val("rst_wr_we", mem_we, 0);
    check_val("rst_wr_count", count, 0);
    check_val("rst_wr_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
    check_val("post_rst_count", count, 0);
    $display("txn reset during WR, count=%0d", count);

    for (int i = 0; i < 80; i++) begin
      logic [2:0]  f;
      logic [31:0] v, r;
      f = 3'($urandom_range(0, 7));
      r = $urandom;
      case (f)
        3'd0, 3'd2: v = {{20{r[11]}}, r[11:0]};
        3'd1:       v = 32'($urandom_range(0, 31));
        3'd3:       v = {{19{r[12]}}, r[12:1], 1'b0};
        3'd4:       v = r & 32'hFFFFF000;
        3'd5:       v = {{11{r[20]}}, r[20:1], 1'b0};
        default:    v = r;
      endcase
      if ($urandom_range(0, 3) == 0) v = $urandom;
      if ((m_cnt == CAP && $urandom_range(0, 1) == 1) || $urandom_range(0, 11) == 0)
        do_clear();
      else
        do_req(f, 7'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encodes decoded RV32I instruction fields back into 32-bit instruction words and writes them sequentially into instruction memory, one word per accepted request. It is the inverse of the control unit's decode path. It serves as the testbench/boot-time program loader, so directed programs are built from fields instead of hand-assembled hex. It sits between a field source (bench or boot FSM) and the instruction-memory write port.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of pointer/count/err; aborts any in-flight word
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
fmt  input  3  000 I, 001 shift-I, 010 S, 011 B, 100 U, 101 J, 110 R, 111 illegal
opcode  input  7  instr[6:0], passed through
funct3  input  3  instr[14:12]
funct7_5  input  1  instr[30] for R and shift-I
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  32  full byte-offset/immediate value, unscrambled
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_WIDTH  word address
mem_wdata  output  32  encoded instruction
count  output  ADDR_WIDTH+1  words written since reset/clear
full  output  1  count == 2^ADDR_WIDTH
err  output  1  sticky: a request was rejected

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready 0 while asserted; mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, err 0.
- FSM IDLE -> ENC -> WR -> IDLE.
- IDLE: in_ready = !full && !clear. Handshake (in_valid && in_ready at edge E0) latches all fields; next state ENC.
- ENC: validate, build word into register at E1. Valid: next state WR. Invalid: err <= 1, next state IDLE, no write.
- WR: mem_we = 1 for exactly one cycle (between E1 and E2), mem_addr = write pointer, mem_wdata = word. At E2: pointer++, count++, state IDLE.
- in_ready is 0 in ENC and WR. Throughput is 1 word per 3 cycles.
- Encoding (bits not listed = 0):
  - R: [30]=funct7_5, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode.
  - I: [31:20]=imm[11:0], rs1/funct3/rd/opcode.
  - shift-I: [30]=funct7_5, [24:20]=imm[4:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0], rs2/rs1/funct3/opcode.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], rs2/rs1/funct3/opcode.
  - U: [31:12]=imm[31:12], rd/opcode.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd/opcode.
- Rejects in ENC:
  - fmt 111.
  - I/S: imm is not a sign-extension of imm[11:0].
  - shift-I: imm[31:5] != 0.
  - B: imm[0] != 0, or imm not sign-extension of imm[12:0].
  - J: imm[0] != 0, or imm not sign-extension of imm[20:0].
  - U: imm[11:0] != 0.
- Full: after the 2^ADDR_WIDTH-th write, full = 1 and in_ready = 0. The pointer wraps to 0 but no write occurs until clear.
- clear (sync):
  - Pointer, count, full and err go to 0; state goes to IDLE.
  - If in ENC/WR, the word is dropped; mem_we is not asserted in the cycle after clear is sampled.
  - clear together with in_valid: no accept.
- rst_n low mid-WR: mem_we drops immediately (async); nothing is counted.
- err only affects that request; later valid requests proceed normally.

Test Plan:
- I addi x1,x0,5 (fmt 000, op 0010011, f3 0, rd 1, imm 5) accepted at E0 -> mem_we high in cycle E1-E2, addr 0, wdata 0x00500093, count 1.
- S sw x2,8(x1) then shift-I srai x5,x5,3 (f3 101, funct7_5 1) -> addr 0 = 0x0020A423, addr 1 = 0x4032D293, count 2, in_ready low for 2 cycles after each accept.
- B beq x0,x0,-4 (imm 0xFFFFFFFC) -> 0xFE000EE3. J jal x1,2048 -> 0x001000EF.
- Illegal: I imm 0x800; B imm 7; fmt 111 -> err 1, no mem_we, count unchanged; next valid addi still written at the next address.
- ADDR_WIDTH=2: 4 writes -> full 1, in_ready 0, count 4. Held in_valid is not accepted. clear -> count 0, full 0, next write to addr 0.
- clear asserted during ENC, and rst_n pulsed low during WR -> no write (mem_we 0 immediately on reset), count stays 0.
